conversor_bin_bcd: RTL and testbench



---
 rtl/conversor_bin_bcd_pkg.sv | 20 ++
 rtl/bcd_ajuste_digito.sv | 7 +
 rtl/conversor_bin_bcd.sv | 96 +++++++++
 tb/tb_conversor_bin_bcd.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/conversor_bin_bcd_pkg.sv
// conversor_pkg: shared FSM encoding and digit-count helper for the binary-to-BCD converter
package conversor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic int min_digits(input int width);
    longint unsigned m;
    int d;
    m = (64'd1 << width) - 64'd1;
    d = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bcd_ajuste_digito.sv
// bcd_ajuste_digito: add 3 to a BCD digit that is 5 or more, before the next left shift
module bcd_ajuste_digito (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);
  assign o_dig = (i_dig >= 4'd5) ? i_dig + 4'd3 : i_dig;
endmodule

// File: rtl/conversor_bin_bcd.sv
// conversor_bin_bcd: iterative double-dabble converter with leading-zero blank mask
module conversor_bin_bcd
  import conversor_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      valor,
  output logic                  busy,
  output logic                  pronto,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  if (DIGITS < min_digits(WIDTH)) begin : g_chk
    $error("conversor_bin_bcd: DIGITS too small for WIDTH");
  end

  state_t              r_state;
  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_pronto;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_blank;
  logic [4*DIGITS-1:0] w_adj;
  logic [DIGITS-1:0]   w_blank;
  logic                w_z;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_ajuste_digito u_adj (
      .i_dig(r_acc[4*g +: 4]),
      .o_dig(w_adj[4*g +: 4])
    );
  end

  // Leading-zero mask: a digit is blank when it and every digit above it are zero
  always_comb begin
    w_blank = '0;
    w_z     = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      w_z        = w_z & (r_acc[4*k +: 4] == 4'd0);
      w_blank[k] = w_z;
    end
  end

  // Control FSM: capture, WIDTH adjust-and-shift steps, then publish the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bin    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_pronto <= 1'b0;
      r_bcd    <= '0;
      r_blank  <= BLANK_RST;
    end else begin
      r_pronto <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_bin   <= valor;
          r_acc   <= '0;
          r_cnt   <= CW'(WIDTH);
          r_busy  <= 1'b1;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_acc <= {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_bcd    <= r_acc;
          r_blank  <= w_blank;
          r_pronto <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign pronto = r_pronto;
  assign bcd    = r_bcd;
  assign blank  = r_blank;
endmodule

// File: tb/tb_conversor_bin_bcd.sv
// tb_conversor_bin_bcd: directed and random scoreboard checks of the binary-to-BCD converter
module tb_conversor_bin_bcd;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] valor = '0;
  logic        busy, pronto;
  logic [19:0] bcd;
  logic [4:0]  blank;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] q_bcd[$];
  logic [4:0]  q_blk[$];

  conversor_bin_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .valor(valor),
    .busy(busy), .pronto(pronto), .bcd(bcd), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int v);
    int nd;
    logic [4:0] r;
    nd = 1;
    while (v >= 10) begin
      v = v / 10;
      nd++;
    end
    r = '0;
    for (int k = 1; k < 5; k++) r[k] = (k >= nd);
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, " bcd"}, bcd, 0);
    check({tag, " blank"}, blank, 5'b11110);
    check({tag, " busy"}, busy, 0);
    check({tag, " pronto"}, pronto, 0);
  endtask

  task automatic launch(input int v, input bit push);
    valor = 16'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (push) begin
      q_bcd.push_back(ref_bcd(v));
      q_blk.push_back(ref_blank(v));
    end
  endtask

  task automatic collect(input string tag, input int n0);
    int n;
    bit ok;
    logic [19:0] eb;
    logic [4:0] el;
    n = n0;
    while (!pronto && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, " busy"}, busy, 1);
    end
    check({tag, " latency"}, n, 17);
    eb = q_bcd.size() > 0 ? q_bcd.pop_front() : 20'hxxxxx;
    el = q_blk.size() > 0 ? q_blk.pop_front() : 5'bxxxxx;
    check({tag, " bcd"}, bcd, eb);
    check({tag, " blank"}, blank, el);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) if (bcd[4*k +: 4] > 4'd9) ok = 1'b0;
    check({tag, " digits<=9"}, ok, 1);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk);
    check({tag, " pulse width"}, pronto, 0);
  endtask

  task automatic count_pronto(input string tag, input int cycles);
    int c;
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      c += int'(pronto);
    end
    check({tag, " spurious pronto"}, c, 0);
  endtask

  initial begin
    int vals[7];
    #1 rst = 1'b1;
    #1 check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    launch(1234, 1);
    collect("1234", 0);
    pulse_end("1234");

    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("async rst");
    @(negedge clk);
    rst = 1'b0;

    launch(65535, 1);
    collect("65535", 0);
    pulse_end("65535");
    launch(0, 1);
    collect("zero", 0);
    pulse_end("zero");

    launch(42, 1);
    repeat (4) @(negedge clk);
    valor = 16'd9999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect("42", 5);
    count_pronto("42", 25);

    launch(500, 0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("mid rst");
    @(negedge clk);
    rst = 1'b0;
    count_pronto("mid rst", 25);
    launch(500, 1);
    collect("500", 0);
    pulse_end("500");

    for (int i = 0; i < 4; i++) begin
      valor = (i % 2 == 1) ? 16'd300 : 16'd7;
      start = 1'b1;
      q_bcd.push_back(ref_bcd(int'(valor)));
      q_blk.push_back(ref_blank(int'(valor)));
      @(negedge clk);
      collect("held", 0);
    end
    start = 1'b0;
    pulse_end("held");

    vals = '{9, 10, 99, 100, 9999, 10000, 65535};
    foreach (vals[i]) begin
      launch(vals[i], 1);
      collect("edge", 0);
    end
    for (int i = 0; i < 1000; i++) begin
      launch(int'($urandom_range(0, 65535)), 1);
      collect("rand", 0);
    end

    check("scoreboard empty", q_bcd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
